ble_conn_monitor: RTL and testbench

- Connection monitor between the UART RX path and the BLE controller FSM.
- Consumes the received byte stream while the controller routes RX to it (rx mux = CONN_MON_RX).
- Detects the BLE module status strings "OK+CONN" and "OK+LOST".
- Produces a registered link-state level plus one-cycle event pulses. The controller uses these to move ADVERTISEMENT <-> CONNECTED.

---
 rtl/ble_ctrl_types_pkg.sv | 20 ++
 rtl/ble_conn_monitor.sv | 132 +++++++++++++
 tb/tb_ble_conn_monitor.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ble_ctrl_types_pkg.sv
// Shared types and constants for the BLE controller and its connection monitor.
// Status strings are the exact byte sequences emitted by the BLE module firmware.
`timescale 1ns/1ps
package ble_ctrl_types_pkg;

  typedef enum logic {
    DISCONNECTED = 1'b0,
    CONNECTED    = 1'b1
  } conn_mon_state_t;

  localparam logic [55:0] CONN_STR     = 56'h4F4B2B434F4E4E;  // "OK+CONN"
  localparam logic [55:0] LOST_STR     = 56'h4F4B2B4C4F5354;  // "OK+LOST"
  localparam int          CONN_MSG_LEN = 7;

  // A window holding 1..6 bytes is a partial string and is subject to the idle timeout
  function automatic logic fill_partial(input logic [2:0] fill);
    return (fill != 3'd0) && (fill < 3'(CONN_MSG_LEN));
  endfunction

endpackage

// File: rtl/ble_conn_monitor.sv
// Watches the UART RX byte stream for "OK+CONN"/"OK+LOST" and tracks link state,
// emitting registered one-cycle pulses on connect, loss and partial-string timeout.
`timescale 1ns/1ps
module ble_conn_monitor
  import ble_ctrl_types_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 250_000,
  parameter int MSG_LEN        = CONN_MSG_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       link_clr,
  output logic       connected,
  output logic       conn_event,
  output logic       lost_event,
  output logic       timeout_event
);

  localparam int HIST_W = (MSG_LEN - 1) * 8;
  localparam int FILL_W = $clog2(MSG_LEN + 1);
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(MSG_LEN);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // The oldest window byte is shifted out on the byte that completes a match,
  // so only the six most recent bytes are stored; the incoming byte is the seventh.
  logic [HIST_W-1:0] hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  conn_mon_state_t   state_q, state_d;
  logic conn_ev_q, conn_ev_d;
  logic lost_ev_q, lost_ev_d;
  logic to_ev_q, to_ev_d;

  logic [HIST_W+7:0] next_win_s;
  logic conn_hit_s, lost_hit_s;

  assign next_win_s = {hist_q, rx_data};
  assign conn_hit_s = (next_win_s == CONN_STR);
  assign lost_hit_s = (next_win_s == LOST_STR);

  always_comb begin
    hist_d    = hist_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    state_d   = state_q;
    conn_ev_d = 1'b0;
    lost_ev_d = 1'b0;
    to_ev_d   = 1'b0;

    if (link_clr) begin
      // Forced disconnect wins over any byte in flight; that byte is dropped
      state_d = DISCONNECTED;
      hist_d  = {HIST_W{1'b0}};
      fill_d  = {FILL_W{1'b0}};
      cnt_d   = {CNT_W{1'b0}};
    end else if (!en) begin
      hist_d = {HIST_W{1'b0}};
      fill_d = {FILL_W{1'b0}};
      cnt_d  = {CNT_W{1'b0}};
    end else if (rx_valid) begin
      cnt_d = {CNT_W{1'b0}};
      if (conn_hit_s || lost_hit_s) begin
        hist_d = {HIST_W{1'b0}};
        fill_d = {FILL_W{1'b0}};
        case (state_q)
          DISCONNECTED: begin
            if (conn_hit_s) begin
              state_d   = CONNECTED;
              conn_ev_d = 1'b1;
            end else begin
              state_d = DISCONNECTED;
            end
          end
          CONNECTED: begin
            if (lost_hit_s) begin
              state_d   = DISCONNECTED;
              lost_ev_d = 1'b1;
            end else begin
              state_d = CONNECTED;
            end
          end
          default: state_d = DISCONNECTED;
        endcase
      end else begin
        hist_d = next_win_s[HIST_W-1:0];
        fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
      end
    end else if (fill_partial(3'(fill_q))) begin
      if (cnt_q == CNT_LAST) begin
        hist_d  = {HIST_W{1'b0}};
        fill_d  = {FILL_W{1'b0}};
        cnt_d   = {CNT_W{1'b0}};
        to_ev_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // State, window, counters and event pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q    <= {HIST_W{1'b0}};
      fill_q    <= {FILL_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      state_q   <= DISCONNECTED;
      conn_ev_q <= 1'b0;
      lost_ev_q <= 1'b0;
      to_ev_q   <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      conn_ev_q <= conn_ev_d;
      lost_ev_q <= lost_ev_d;
      to_ev_q   <= to_ev_d;
    end
  end

  assign connected     = (state_q == CONNECTED);
  assign conn_event    = conn_ev_q;
  assign lost_event    = lost_ev_q;
  assign timeout_event = to_ev_q;

endmodule

// File: tb/tb_ble_conn_monitor.sv
// Directed bench for ble_conn_monitor: a table of per-byte vectors plus
// hand-written sequences for timeout, timeout/byte race and mid-string reset.
`timescale 1ns/1ps
module tb_ble_conn_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       link_clr;
  logic       connected, conn_event, lost_event, timeout_event;
  logic [3:0] outs;

  int checks   = 0;
  int failures = 0;
  logic cur_c;

  typedef struct {
    logic       en;
    logic [7:0] data;
    logic       lc;
    int         gap;
    logic [3:0] exp;  // {connected, conn_event, lost_event, timeout_event}
  } vec_t;

  vec_t vecs[$];

  ble_conn_monitor #(.TIMEOUT_CYCLES(20)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .link_clr      (link_clr),
    .connected     (connected),
    .conn_event    (conn_event),
    .lost_event    (lost_event),
    .timeout_event (timeout_event)
  );

  always #5 clk = ~clk;

  assign outs = {connected, conn_event, lost_event, timeout_event};

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: {conn,ce,le,te} actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic e, input logic v, input logic [7:0] d, input logic lc);
    @(negedge clk);
    en       = e;
    rx_valid = v;
    rx_data  = d;
    link_clr = lc;
    @(posedge clk);
    #1;
  endtask

  task automatic add_str(input string s, input logic e, input logic lc_last, input int gap,
                         input logic c_mid, input logic c_end, input logic ce, input logic le);
    for (int i = 0; i < s.len(); i++) begin
      vec_t v;
      v.en   = e;
      v.data = s[i];
      v.gap  = gap;
      if (i == s.len() - 1) begin
        v.lc  = lc_last;
        v.exp = {c_end, ce, le, 1'b0};
      end else begin
        v.lc  = 1'b0;
        v.exp = {c_mid, 3'b000};
      end
      vecs.push_back(v);
    end
  endtask

  task automatic send_chk(input string s, input string name, input logic [3:0] exp_mid,
                          input logic [3:0] exp_last);
    for (int i = 0; i < s.len(); i++) begin
      cyc(1'b1, 1'b1, 8'(s[i]), 1'b0);
      chk(name, outs, (i == s.len() - 1) ? exp_last : exp_mid);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    en       = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    link_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", outs, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    link_clr = 1'b0;

    add_str("OK+CONN",   1'b1, 1'b0, 10, 1'b0, 1'b1, 1'b1, 1'b0);  // connect
    add_str("AB",        1'b1, 1'b0,  2, 1'b1, 1'b1, 1'b0, 1'b0);  // noise prefix
    add_str("OK+LOST",   1'b1, 1'b0,  2, 1'b1, 1'b0, 1'b0, 1'b1);  // lost
    add_str("OK+CONN",   1'b1, 1'b0,  1, 1'b0, 1'b1, 1'b1, 1'b0);
    add_str("OK+CONN",   1'b1, 1'b0,  0, 1'b1, 1'b1, 1'b0, 1'b0);  // duplicate, back-to-back
    add_str("OK+LOST",   1'b1, 1'b1,  1, 1'b1, 1'b0, 1'b0, 1'b0);  // link_clr on 'T'
    add_str("OK+CONN",   1'b1, 1'b1,  1, 1'b0, 1'b0, 1'b0, 1'b0);  // link_clr on 'N'
    add_str("XXOK+CONN", 1'b1, 1'b0,  1, 1'b0, 1'b1, 1'b1, 1'b0);  // sliding window
    add_str("OK+LOST",   1'b0, 1'b0,  1, 1'b1, 1'b1, 1'b0, 1'b0);  // en=0 keeps link
    add_str("OK+LOST",   1'b1, 1'b0,  3, 1'b1, 1'b0, 1'b0, 1'b1);
    add_str("OK+LOST",   1'b1, 1'b0,  1, 1'b0, 1'b0, 1'b0, 1'b0);  // duplicate lost
    add_str("OK+CONN",   1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b0, 1'b0);  // en=0, no connect

    do_reset();
    cur_c = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      for (int g = 0; g < vecs[i].gap; g++) begin
        cyc(vecs[i].en, 1'b0, 8'h00, 1'b0);
        chk($sformatf("idle_before_vec%0d", i), outs, {cur_c, 3'b000});
      end
      cyc(vecs[i].en, 1'b1, vecs[i].data, vecs[i].lc);
      chk($sformatf("vec%0d", i), outs, vecs[i].exp);
      cur_c = vecs[i].exp[3];
    end

    // Partial string expires exactly 20 cycles after the last byte
    do_reset();
    send_chk("OK+C", "timeout_prefix", 4'b0000, 4'b0000);
    for (int k = 1; k <= 25; k++) begin
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      chk($sformatf("timeout_idle%0d", k), outs, {3'b000, (k == 20)});
    end
    send_chk("ONN", "timeout_tail", 4'b0000, 4'b0000);

    // A byte landing on the expiry cycle beats the timeout
    do_reset();
    send_chk("OK+C", "race_prefix", 4'b0000, 4'b0000);
    for (int k = 1; k <= 19; k++) begin
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      chk("race_idle", outs, 4'b0000);
    end
    send_chk("ONN", "race_tail", 4'b0000, 4'b1100);

    // Asynchronous reset mid-string discards the partial window and the link
    send_chk("OK+CO", "rst_prefix", 4'b1000, 4'b1000);
    @(negedge clk);
    rst      = 1'b1;
    rx_valid = 1'b0;
    #1;
    chk("async_reset", outs, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    send_chk("NN", "rst_tail", 4'b0000, 4'b0000);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    send_chk("OK+CONN", "rst_reconnect", 4'b0000, 4'b1100);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("pulse_one_cycle", outs, 4'b1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
